// File: rtl/sd_sector_uart_dump.sv
// sd_sector_uart_dump: reads one 512-byte SD sector through the SPI
// controller's read port into a 256x16 buffer and streams it to the UART
// transmitter as paced byte slots, high byte of each word first.
module sd_sector_uart_dump #(
    parameter int BYTE_PERIOD  = 2000,  // clk_sd cycles per byte slot
    parameter int TX_EN_CYCLES = 4      // uart_tx_enable stretch, < BYTE_PERIOD
) (
    input  logic        clk_sd,
    input  logic        reset_n,
    input  logic        sd_init_done,
    input  logic        dump_start,
    input  logic [31:0] dump_sec_addr,
    input  logic        rd_busy,
    input  logic        rd_en,
    input  logic [15:0] rd_data,
    output logic        rd_start_en,
    output logic [31:0] rd_sec_addr,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_enable,
    output logic        dump_busy,
    output logic        dump_done,
    output logic        dump_err
);

    localparam int SW = (BYTE_PERIOD > 2) ? $clog2(BYTE_PERIOD) : 1;
    localparam logic [15:0] TIMEOUT_LAST = 16'hFFFE;  // 65535 cycles in WAIT_RD

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_RD, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [15:0]    mem [0:255];
    logic [7:0]     wr_ptr;
    logic [8:0]     wr_cnt;
    logic [9:0]     tx_cnt;
    logic [15:0]    to_cnt;
    logic [SW-1:0]  slot_cnt;     // cycles left in the current slot, 0 = idle
    logic [15:0]    rd_word;
    logic [8:0]     cnt_final;    // word count including a write this cycle
    logic           accept, wr_ok, tx_go, tx_done, slot_idle, timeout;

    assign accept    = (state == S_IDLE) && dump_start && sd_init_done;
    assign wr_ok     = (state == S_STREAM) && rd_en && !wr_cnt[8];
    assign slot_idle = (slot_cnt == '0);
    // Only words already written are ever sent: tx_cnt must trail 2*wr_cnt.
    assign tx_go     = ((state == S_STREAM) || (state == S_DRAIN)) && slot_idle
                       && (tx_cnt < {wr_cnt, 1'b0});
    assign tx_done   = slot_idle && (tx_cnt == {wr_cnt, 1'b0});
    assign timeout   = !rd_busy && (to_cnt == TIMEOUT_LAST);
    assign cnt_final = wr_cnt + {8'd0, wr_ok};
    assign rd_word   = mem[tx_cnt[9:1]];

    assign rd_start_en = (state == S_REQ);
    assign dump_busy   = (state != S_IDLE);
    assign dump_done   = (state == S_DONE);

    // State register.
    always_ff @(posedge clk_sd or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = S_REQ;
            S_REQ:     state_nxt = S_WAIT_RD;
            S_WAIT_RD: if (rd_busy) state_nxt = S_STREAM;
                       else if (timeout) state_nxt = S_DONE;
            S_STREAM:  if (!rd_busy) state_nxt = S_DRAIN;
            S_DRAIN:   if (tx_done) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Capture counters, timeout, sticky error and the byte-slot transmitter.
    always_ff @(posedge clk_sd or negedge reset_n) begin
        if (!reset_n) begin
            rd_sec_addr    <= '0;
            wr_ptr         <= '0;
            wr_cnt         <= '0;
            tx_cnt         <= '0;
            to_cnt         <= '0;
            slot_cnt       <= '0;
            uart_tx_data   <= '0;
            uart_tx_enable <= 1'b0;
            dump_err       <= 1'b0;
        end else begin
            if (accept) begin
                rd_sec_addr <= dump_sec_addr;
                wr_ptr      <= '0;
                wr_cnt      <= '0;
                tx_cnt      <= '0;
                dump_err    <= 1'b0;
            end

            to_cnt <= (state == S_WAIT_RD) ? to_cnt + 16'd1 : 16'd0;
            if ((state == S_WAIT_RD) && timeout) dump_err <= 1'b1;

            if (wr_ok) begin
                wr_ptr <= wr_ptr + 8'd1;
                wr_cnt <= wr_cnt + 9'd1;
            end
            // Words past 256 are dropped; a short burst is flagged at its end.
            if ((state == S_STREAM) && rd_en && wr_cnt[8]) dump_err <= 1'b1;
            if ((state == S_STREAM) && !rd_busy && (cnt_final != 9'd256))
                dump_err <= 1'b1;

            if (tx_go) begin
                uart_tx_data   <= tx_cnt[0] ? rd_word[7:0] : rd_word[15:8];
                tx_cnt         <= tx_cnt + 10'd1;
                slot_cnt       <= SW'(BYTE_PERIOD - 1);
                uart_tx_enable <= 1'b1;
            end else begin
                if (!slot_idle) slot_cnt <= slot_cnt - SW'(1);
                if (slot_cnt == SW'(BYTE_PERIOD - TX_EN_CYCLES))
                    uart_tx_enable <= 1'b0;
            end
        end
    end

    // Sector buffer write port; read is the combinational rd_word above.
    always_ff @(posedge clk_sd) begin
        if (wr_ok) mem[wr_ptr] <= rd_data;
    end

endmodule
